// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard key source: scancode prefixes,
// the key-status encoding on the state output and the decoder FSM states.
package ps2_pkg;

   // Scancode prefix bytes (set 2).
   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;

   // A PS/2 frame: start, 8 data bits, odd parity, stop.
   localparam int FRAME_BITS = 11;

   // Key status as presented on the state output.
   typedef enum logic [1:0] {
      KEY_NONE  = 2'b00,
      KEY_ASCII = 2'b01,
      KEY_OTHER = 2'b10
   } key_state_e;

   // Scancode decoder states.
   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      BRK     = 2'b01,
      EXT     = 2'b10,
      EXT_BRK = 2'b11
   } dec_state_e;

endpackage : ps2_pkg

// File: rtl/ps2_key_source_if.sv
// Bundle between the keyboard side (raw PS/2 lines) and the consumer of key
// status. pop_hold, fifo_level and dec_fsm expose the scancode queue so a
// host can stall decoding and observe the queue and decoder.
interface ps2_key_source_if;
   import ps2_pkg::*;

   logic       ps2_clk;
   logic       ps2_data;
   logic [1:0] state;
   logic [7:0] kbd_ascii;
   logic       overflow;
   logic       frame_err;
   logic       pop_hold;    // 1: decoder leaves queued bytes in the FIFO
   logic [7:0] fifo_level;  // bytes currently queued
   dec_state_e dec_fsm;     // current decoder state

   // Drives the keyboard lines and the hold control, receives status.
   modport master (
      output ps2_clk, ps2_data, pop_hold,
      input  state, kbd_ascii, overflow, frame_err, fifo_level, dec_fsm
   );

   // The key source itself.
   modport slave (
      input  ps2_clk, ps2_data, pop_hold,
      output state, kbd_ascii, overflow, frame_err, fifo_level, dec_fsm
   );

endinterface : ps2_key_source_if

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronizes the raw keyboard lines, shifts in one
// bit per ps2_clk falling edge and emits each good byte with a one-cycle
// valid pulse. Bad frames raise a one-cycle frame_err instead. A frame that
// stalls for TIMEOUT_CYC cycles is silently abandoned.
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       frame_err
);

   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   logic [2:0]    clk_sync;
   logic [2:0]    data_sync;
   logic          fall;
   logic          data_bit;
   logic [3:0]    bit_cnt;
   logic [10:0]   shift_q;
   logic [10:0]   frame_next;
   logic [TW-1:0] to_cnt;
   logic          last_bit;
   logic          frame_ok;

   // Three-flop synchronizers; idle PS/2 lines are high, so reset to 1.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         clk_sync  <= 3'b111;
         data_sync <= 3'b111;
      end else begin
         clk_sync  <= {clk_sync[1:0], ps2_clk};
         data_sync <= {data_sync[1:0], ps2_data};
      end
   end

   // Falling edge seen on the two oldest clock flops; the oldest data flop
   // holds the bit that was stable just before that edge.
   assign fall     = clk_sync[2] & ~clk_sync[1];
   assign data_bit = data_sync[2];

   // Bits arrive LSB first, so each new bit enters at the top.
   assign frame_next = {data_bit, shift_q[10:1]};
   assign last_bit   = (bit_cnt == 4'(FRAME_BITS - 1));
   assign frame_ok   = ~frame_next[0] & frame_next[10] & (^frame_next[9:1]);

   // Bit counter, shift register, inactivity timeout and result pulses.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         bit_cnt   <= '0;
         shift_q   <= '0;
         to_cnt    <= '0;
         rx_byte   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         if (fall) begin
            to_cnt  <= '0;
            shift_q <= frame_next;
            if (last_bit) begin
               bit_cnt <= '0;
               rx_byte <= frame_next[8:1];
               if (frame_ok) rx_valid  <= 1'b1;
               else          frame_err <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + 4'd1;
            end
         end else if (bit_cnt != '0) begin
            // Mid-frame with no edge: give up quietly once the budget expires.
            if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
               bit_cnt <= '0;
               to_cnt  <= '0;
            end else begin
               to_cnt <= to_cnt + TW'(1);
            end
         end
      end
   end

endmodule : ps2_rx_frame

// File: rtl/ps2_key_source.sv
// PS/2 keyboard key source: frame receiver, scancode FIFO, make/break
// decoder and scancode-to-ASCII table. Reports the most recent printable key
// and whether a key is currently held.
module ps2_key_source
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,      // power of two, at least 2
   parameter int TIMEOUT_CYC = 50000
) (
   input logic              clk,
   input logic              clrn,
   ps2_key_source_if.slave  kbd
);

   localparam int AW = $clog2(FIFO_DEPTH);

   // Set-2 make code to lowercase ASCII; unmapped keys give 0.
   function automatic logic [7:0] scan_to_ascii(input logic [7:0] sc);
      logic [7:0] a;
      case (sc)
         8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
         8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
         8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
         8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
         8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
         8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
         8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
         8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
         8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
         8'h3E: a = 8'h38; 8'h46: a = 8'h39;
         8'h29: a = 8'h20;
         8'h5A: a = 8'h0D;
         default: a = 8'h00;
      endcase
      return a;
   endfunction

   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       rx_err;

   ps2_rx_frame #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_rx (
      .clk       (clk),
      .clrn      (clrn),
      .ps2_clk   (kbd.ps2_clk),
      .ps2_data  (kbd.ps2_data),
      .rx_byte   (rx_byte),
      .rx_valid  (rx_valid),
      .frame_err (rx_err)
   );

   // ---------------------------------------------------------------- FIFO
   logic [7:0] mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [AW:0] level;
   logic        empty;
   logic        full;
   logic        do_pop;
   logic        do_push;
   logic        overflow_q;
   logic [7:0]  pop_byte;

   // Extra pointer MSB tells a wrapped (full) queue from an empty one.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop   = ~empty & ~kbd.pop_hold;
   // A pop in the same cycle frees the slot, so a full queue still accepts.
   assign do_push  = rx_valid & (~full | do_pop);
   assign level    = wr_ptr - rd_ptr;
   assign pop_byte = mem[rd_ptr[AW-1:0]];

   // Storage array.
   // NOTE: the data array has no reset; the pointers alone define which
   // entries are valid, and leaving it unreset lets it map onto RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= rx_byte;
   end

   // Pointers and the sticky overflow flag.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (rx_valid && full && !do_pop) overflow_q <= 1'b1;
      end
   end

   // ------------------------------------------------------------- decoder
   dec_state_e fsm_q, fsm_d;
   key_state_e key_q, key_d;
   logic [7:0] ascii_q, ascii_d;
   logic [7:0] held_q, held_d;
   logic [7:0] pop_ascii;

   // Decoder registers: FSM state, key status, last ASCII and held code.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         fsm_q   <= IDLE;
         key_q   <= KEY_NONE;
         ascii_q <= 8'h00;
         held_q  <= 8'h00;
      end else begin
         fsm_q   <= fsm_d;
         key_q   <= key_d;
         ascii_q <= ascii_d;
         held_q  <= held_d;
      end
   end

   // Next-state logic: consumes one queued byte per cycle.
   // NOTE: every output of this block is given a default first, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      fsm_d     = fsm_q;
      key_d     = key_q;
      ascii_d   = ascii_q;
      held_d    = held_q;
      pop_ascii = scan_to_ascii(pop_byte);
      if (do_pop) begin
         case (fsm_q)
            IDLE: begin
               if (pop_byte == SC_BREAK) begin
                  fsm_d = BRK;
               end else if (pop_byte == SC_EXT) begin
                  fsm_d = EXT;
               end else if (pop_byte != held_q) begin
                  // New make code; a repeat of the held key is ignored.
                  held_d = pop_byte;
                  if (pop_ascii != 8'h00) begin
                     ascii_d = pop_ascii;
                     key_d   = KEY_ASCII;
                  end else begin
                     key_d   = KEY_OTHER;
                  end
               end
            end
            BRK: begin
               // Only the release of the currently held key clears status.
               if (pop_byte == held_q) begin
                  key_d  = KEY_NONE;
                  held_d = 8'h00;
               end
               fsm_d = IDLE;
            end
            EXT: begin
               fsm_d = (pop_byte == SC_BREAK) ? EXT_BRK : IDLE;
            end
            EXT_BRK: begin
               fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
         endcase
      end
   end

   assign kbd.state      = key_q;
   assign kbd.kbd_ascii  = ascii_q;
   assign kbd.overflow   = overflow_q;
   assign kbd.frame_err  = rx_err;
   assign kbd.fifo_level = 8'(level);
   assign kbd.dec_fsm    = fsm_q;

endmodule : ps2_key_source

// File: tb/tb_ps2_key_source.sv
// Directed testbench for ps2_key_source: bit-bangs PS/2 frames and checks
// key status, error pulses, FIFO overflow, timeout and reset recovery.
module tb_ps2_key_source;
   import ps2_pkg::*;

   localparam int HALF = 8;     // clk cycles per PS/2 clock half-period
   localparam int GAP  = 12;    // idle clk cycles after each frame

   logic clk;
   logic clrn;
   int   n_chk;
   int   n_err;
   int   err_pulses;

   ps2_key_source_if kbd ();

   ps2_key_source #(
      .FIFO_DEPTH  (8),
      .TIMEOUT_CYC (200)
   ) dut (
      .clk  (clk),
      .clrn (clrn),
      .kbd  (kbd.slave)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Count cycles during which frame_err is high.
   initial err_pulses = 0;
   always @(negedge clk) if (kbd.frame_err) err_pulses++;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Send the first nbits of a frame for byte b; optionally corrupt parity.
   task automatic send_bits(input logic [7:0] b, input int nbits,
                            input bit bad_par);
      logic [10:0] f;
      f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         kbd.ps2_data = f[i];
         repeat (HALF) @(negedge clk);
         kbd.ps2_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         kbd.ps2_clk = 1'b1;
      end
      repeat (HALF) @(negedge clk);
      kbd.ps2_data = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b);
      send_bits(b, 11, 1'b0);
      repeat (GAP) @(negedge clk);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      clrn = 1'b0;
      repeat (3) @(negedge clk);
      clrn = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int e0;
      n_chk = 0;
      n_err = 0;
      kbd.ps2_clk  = 1'b1;
      kbd.ps2_data = 1'b1;
      kbd.pop_hold = 1'b0;
      clrn = 1'b0;

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_state",    kbd.state,      2'b00);
      check("rst_ascii",    kbd.kbd_ascii,  8'h00);
      check("rst_overflow", kbd.overflow,   1'b0);
      check("rst_ferr",     kbd.frame_err,  1'b0);
      check("rst_level",    kbd.fifo_level, 8'd0);
      check("rst_fsm",      kbd.dec_fsm,    IDLE);
      clrn = 1'b1;
      repeat (2) @(negedge clk);

      // Press and release 'a'.
      send_frame(8'h1C);
      check("a_state", kbd.state,     2'b01);
      check("a_ascii", kbd.kbd_ascii, 8'h61);
      send_frame(8'hF0);
      send_frame(8'h1C);
      check("a_rel_state", kbd.state,     2'b00);
      check("a_rel_ascii", kbd.kbd_ascii, 8'h61);

      // Parity error: one frame_err pulse, nothing queued.
      kbd.pop_hold = 1'b1;
      e0 = err_pulses;
      send_bits(8'h1C, 11, 1'b1);
      repeat (GAP) @(negedge clk);
      check("par_pulses", err_pulses - e0, 1);
      check("par_state",  kbd.state,       2'b00);
      check("par_level",  kbd.fifo_level,  8'd0);
      kbd.pop_hold = 1'b0;

      // Extended make and break are discarded.
      send_frame(8'hE0);
      check("ext_fsm", kbd.dec_fsm, EXT);
      send_frame(8'h75);
      send_frame(8'hE0);
      send_frame(8'hF0);
      check("extbrk_fsm", kbd.dec_fsm, EXT_BRK);
      send_frame(8'h75);
      check("ext_state", kbd.state,   2'b00);
      check("ext_idle",  kbd.dec_fsm, IDLE);

      // Typematic repeats, then a second key takes over.
      send_frame(8'h1C);
      send_frame(8'h1C);
      send_frame(8'h1C);
      check("typ_state", kbd.state,     2'b01);
      check("typ_ascii", kbd.kbd_ascii, 8'h61);
      send_frame(8'h1B);
      check("s_state", kbd.state,     2'b01);
      check("s_ascii", kbd.kbd_ascii, 8'h73);
      send_frame(8'hF0);
      send_frame(8'h1C);
      check("old_rel_state", kbd.state,     2'b01);
      check("old_rel_ascii", kbd.kbd_ascii, 8'h73);
      send_frame(8'hF0);
      send_frame(8'h1B);
      check("s_rel_state", kbd.state,     2'b00);
      check("s_rel_ascii", kbd.kbd_ascii, 8'h73);

      // Non-printable key (F1).
      send_frame(8'h05);
      check("np_state", kbd.state,     2'b10);
      check("np_ascii", kbd.kbd_ascii, 8'h73);
      send_frame(8'hF0);
      send_frame(8'h05);
      check("np_rel_state", kbd.state, 2'b00);

      // Stalled partial frame times out silently; next frame decodes.
      e0 = err_pulses;
      send_bits(8'h5A, 4, 1'b0);
      repeat (300) @(negedge clk);
      send_frame(8'h29);
      check("to_pulses", err_pulses - e0, 0);
      check("to_ascii",  kbd.kbd_ascii,   8'h20);
      check("to_state",  kbd.state,       2'b01);
      send_frame(8'hF0);
      send_frame(8'h29);
      check("to_rel_state", kbd.state, 2'b00);

      // Nine frames with decoding stalled: eight kept, ninth lost.
      kbd.pop_hold = 1'b1;
      send_frame(8'h16);
      send_frame(8'h1E);
      send_frame(8'h26);
      send_frame(8'h25);
      send_frame(8'h2E);
      send_frame(8'h36);
      send_frame(8'h3D);
      send_frame(8'h1C);
      check("full_ovf", kbd.overflow, 1'b0);
      send_frame(8'h1B);
      check("ovf_flag",  kbd.overflow,   1'b1);
      check("ovf_level", kbd.fifo_level, 8'd8);
      kbd.pop_hold = 1'b0;
      repeat (20) @(negedge clk);
      check("drain_level", kbd.fifo_level, 8'd0);
      check("drain_ascii", kbd.kbd_ascii,  8'h61);
      check("drain_state", kbd.state,      2'b01);
      check("ovf_sticky",  kbd.overflow,   1'b1);
      send_frame(8'hF0);
      send_frame(8'h1C);
      check("drain_rel", kbd.state, 2'b00);

      // Reset mid-frame, then a clean 0x29 frame.
      e0 = err_pulses;
      send_bits(8'h29, 5, 1'b0);
      pulse_reset();
      check("mrst_ovf",   kbd.overflow,  1'b0);
      check("mrst_ascii", kbd.kbd_ascii, 8'h00);
      check("mrst_state", kbd.state,     2'b00);
      send_frame(8'h29);
      check("mrst_pulses", err_pulses - e0, 0);
      check("sp_ascii",    kbd.kbd_ascii,   8'h20);
      check("sp_state",    kbd.state,       2'b01);
      check("sp_level",    kbd.fifo_level,  8'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule : tb_ps2_key_source

// File: doc/ps2_key_source.md
PS2_KEY_SOURCE -- requirements
Module: ps2_key_source

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, scancode FIFO entries (power of two).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000, clk cycles without a PS/2 falling edge before a partial frame is discarded.
REQ-003 SHALL have port clk  input  1  system clock (50 MHz), sole clock.
REQ-004 SHALL have port clrn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous.
REQ-006 SHALL have port ps2_data  input  1  raw PS/2 data, asynchronous.
REQ-007 SHALL have port state  output  2  key status: 00 none, 01 key held (kbd_ascii valid), 10 non-printable key held, 11 unused.
REQ-008 SHALL have port kbd_ascii  output  8  ASCII of the most recently pressed printable key.
REQ-009 SHALL have port overflow  output  1  sticky: a good frame arrived while the FIFO was full.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on a start, stop or parity error.

Function
REQ-011 SHALL pass ps2_clk and ps2_data through 3-flop synchronizers and detect ps2_clk falling edges from the two oldest flops.
REQ-012 SHALL sample synchronized ps2_data on each falling edge into an 11-bit frame, LSB first: start, 8 data, odd parity, stop.
REQ-013 SHALL, after the 11th edge, accept the frame only if start==0, stop==1 and the XOR of data and parity ==1; otherwise pulse frame_err for one cycle and drop the frame.
REQ-014 SHALL push each accepted byte into the FIFO in the cycle after the 11th edge; a push when full is dropped and sets overflow.
REQ-015 SHALL clear the bit counter when TIMEOUT_CYC cycles pass mid-frame without a falling edge; no frame_err is raised.
REQ-016 SHALL have a decoder FSM with states IDLE, BRK, EXT, EXT_BRK that pops at most one byte per cycle while the FIFO is non-empty.
REQ-017 SHALL in IDLE: on 0xF0 go to BRK; on 0xE0 go to EXT; on any other byte treat it as a make code and stay in IDLE.
REQ-018 SHALL on a make code mapping to nonzero ASCII: set kbd_ascii to that value, record the scancode as held, and set state=01 on the next cycle.
REQ-019 SHALL on a make code that maps to 0: record it as held, set state=10, and leave kbd_ascii unchanged.
REQ-020 SHALL ignore typematic repeats (a make code equal to the held code): state and kbd_ascii stay unchanged.
REQ-021 SHALL in BRK: if the byte equals the held code, set state=00 and clear held; otherwise change nothing; return to IDLE.
REQ-022 SHALL in EXT, discard the byte and go to IDLE, or go to EXT_BRK on 0xF0; EXT_BRK SHALL discard the next byte and go to IDLE.
REQ-023 SHALL map scancodes to ASCII: letters to lowercase 0x61-0x7A (0x1C->'a', 0x1B->'s'); top-row digits to 0x30-0x39; 0x29->0x20; 0x5A->0x0D; all others to 0.
REQ-024 SHALL take at most 3 clk cycles from FIFO push to the resulting state update when the FIFO was empty.
REQ-025 SHALL, on a new printable make while another key is held, switch held, kbd_ascii and state to the new key; the later break of the old key is ignored.
REQ-026 SHALL keep FIFO pointers one bit wider than log2(FIFO_DEPTH), with full/empty by MSB compare; a simultaneous push and pop when full SHALL succeed without setting overflow.

Reset
REQ-027 SHALL on clrn low asynchronously clear: state=00, kbd_ascii=0x00, overflow=0, frame_err=0, FIFO empty, FSM=IDLE, held=0x00, bit counter=0, timeout counter=0, synchronizer flops=1.
REQ-028 SHALL discard any partial frame on a reset asserted mid-frame and restart cleanly at the next start bit after release.

Structure
REQ-029 SHALL place the scancode constants (0xF0, 0xE0), the state encodings (00/01/10) and the FSM state enum in a shared package, ps2_pkg.
REQ-030 SHALL implement frame reception (REQ-011 to REQ-015) as one sub-module, ps2_rx_frame, which outputs a byte with a one-cycle valid pulse.
REQ-031 SHALL implement the FIFO, decoder FSM and ASCII table in ps2_key_source itself.

Verification
REQ-032 SHALL verify: frame 0x1C, then F0 1C -> state 01 and kbd_ascii=0x61, then state 00 with kbd_ascii still 0x61.
REQ-033 SHALL verify: frame 0x1C with the parity bit inverted -> frame_err pulses once, state stays 00 and FIFO stays empty.
REQ-034 SHALL verify: E0 75 then E0 F0 75 -> state stays 00 and the FSM ends in IDLE.
REQ-035 SHALL verify: 9 frames with the pop held off -> overflow=1, 8 bytes retained, and the 9th byte lost.
REQ-036 SHALL verify: 1C 1C 1C (typematic), then 1B while 1C is held -> kbd_ascii=0x73 and state 01; F0 1C -> no change; F0 1B -> state 00.
REQ-037 SHALL verify: clrn pulsed after 5 bits of a frame, then a full 0x29 frame -> only 0x29 decoded, kbd_ascii=0x20, state 01.
